prach_tdm_mux: RTL
==================

# prach_tdm_mux

Per-channel-to-TDM multiplexer that produces the time-division PRACH sample stream consumed by the channel mixer. Each antenna-carrier channel delivers samples on its own valid strobe. Samples from each channel are buffered in a small per-channel FIFO and emitted one channel per clock slot as a round-robin TDM stream. The output carries 3 parallel I/Q lanes, a channel index, and a frame-sync marker aligned to slot 0.

## Interface

Parameters:
- NUM_CHN, 8: TDM slots per round, range 2..8; slot index runs 0..NUM_CHN-1.
- FIFO_DEPTH, 4: entries per channel FIFO, power of two, at least 2.

Ports:
- clk  in  1  single processing clock.
- rst_n  in  1  asynchronous, active-low reset.
- din_dq  in  32 x 3 x NUM_CHN  per channel, 3 lanes, each {Q[31:16], I[15:0]}.
- din_dv  in  NUM_CHN  per-channel sample valid; one bit per channel covers all 3 lanes.
- sync_in  in  1  one-cycle frame strobe: realigns the slot counter and flushes all FIFOs.
- dout_dq  out  32 x 3  TDM lanes, same packing as din_dq.
- dout_dv  out  1  dout_dq valid.
- dout_chn  out  8  slot/channel index of the current output cycle.
- sync_out  out  1  marks the first slot-0 output cycle after sync_in.
- ctrl_chn_en  in  NUM_CHN  per-channel enable; quasi-static.
- ctrl_ovf_clr  in  1  one-cycle pulse that clears stat_ovf.
- stat_ovf  out  NUM_CHN  sticky overflow flag per channel.

## Operation

- Slot counter s:
  - Reset value 0.
  - Increments every clock and wraps from NUM_CHN-1 to 0.
  - Free-running; it never stalls.
- Write side, per channel k:
  - If din_dv[k]=1 and ctrl_chn_en[k]=1, the 3-lane word is written to FIFO[k].
  - A disabled channel ignores din_dv.
- Overflow:
  - A write to a full FIFO (with no pop in the same cycle) drops the sample.
  - The dropped sample sets stat_ovf[k]; FIFO contents are unchanged.
- Full FIFO with simultaneous pop: the write is accepted and occupancy stays at FIFO_DEPTH.
- Read side: in cycle c, if FIFO[s] holds an entry (occupancy registered before cycle c) and ctrl_chn_en[s]=1, the head is popped into the output register.
- No bypass: a sample written into an empty FIFO in cycle c cannot be popped before cycle c+1.
- Output register:
  - dout_chn = s of the previous cycle, always, even when dout_dv=0.
  - When nothing is popped, dout_dq holds its last value and dout_dv=0.
- sync_in=1 in cycle c:
  - No pop occurs in cycle c.
  - At the end of cycle c, all FIFOs are emptied, writes in cycle c are discarded, and s is set to 0.
  - sync_out=1 in cycle c+2 (the output of slot 0), for exactly one cycle, independent of dout_dv.
- sync_in asserted again before the pending sync_out: sync handling restarts and only one sync_out is produced, for the last sync_in.
- stat_ovf:
  - ctrl_ovf_clr clears all bits at the end of its cycle.
  - If an overflow occurs in the same cycle as ctrl_ovf_clr, the set wins.
  - sync_in does not clear stat_ovf.
- Reset, asynchronous including mid-stream:
  - s=0, all FIFOs empty, dout_dq=0, dout_dv=0, dout_chn=0, sync_out=0, stat_ovf=0.
  - After reset, the output is unsynchronised until the first sync_in; sync_out is never asserted without a sync_in.

## Timing

- Sample latency: from din_dv (cycle c) to the matching dout_dv, the minimum is 2 cycles (written at c, popped at c+1 when s=k, output at c+2).
- Maximum latency for a non-overflowing channel: 1 + FIFO_DEPTH·NUM_CHN cycles.
- Sustainable input rate per channel: one sample per NUM_CHN cycles; bursts are absorbed up to FIFO_DEPTH.
- All outputs are registered; there is no combinational input-to-output path.
- ctrl_chn_en changes take effect at the next cycle edge.
- A channel disabled while its FIFO is non-empty retains its entries and resumes draining when re-enabled.

## Test plan

- NUM_CHN=8, reset, then sync_in at cycle 10; each channel k sends one sample with I=k, Q=0x100+k once every 8 cycles. Required response:
  - sync_out at cycle 12 with dout_chn=0.
  - dout_chn sequence 0..7 repeating.
  - Every dout_dq matches its channel with no loss; stat_ovf=0.
- Channel 3 writes in 6 consecutive cycles while its slot is far away; FIFO_DEPTH=4. Required response:
  - The first 4 samples emerge in order on successive slot-3 outputs.
  - Samples 5 and 6 are dropped; stat_ovf[3]=1 and stays set.
  - ctrl_ovf_clr then clears it to 0.
- Write to an empty FIFO[2] in the cycle where s=2. Required response:
  - Not popped in that slot (dout_dv=0 for dout_chn=2 at c+1).
  - Emitted on the next slot-2 output, 8 cycles later.
- sync_in while FIFOs hold 3 entries each. Required response:
  - All entries are flushed and no stale data appears afterwards.
  - sync_out fires 2 cycles later with dout_chn=0 and dout_dv=0.
- Set ctrl_chn_en[5]=0 with 2 samples queued. Required response:
  - Slot 5 outputs dout_dv=0 and new writes to channel 5 are ignored.
  - After re-enabling, both queued samples emerge on the next two slot-5 outputs.
- Assert rst_n low mid-stream, asynchronously between edges. Required response:
  - All outputs go to 0 immediately.
  - After release, the stream resumes from s=0 and sync_out stays 0 until a new sync_in.

Source files
------------

// File: rtl/prach_tdm_mux.sv
// prach_tdm_mux: buffers per-channel PRACH samples and emits them as a round-robin TDM stream
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   din_dq[NUM_CHN*96]    per channel 3 lanes of {Q[31:16], I[15:0]}; channel k at [k*96 +: 96]
//   din_dv[NUM_CHN]       per-channel sample valid
//   sync_in               frame strobe: flushes FIFOs, realigns slot counter to 0
//   dout_dq[96]           TDM output lanes, dout_dv its valid, dout_chn the slot index
//   sync_out              marks the slot-0 output two cycles after sync_in
//   ctrl_chn_en           per-channel enable, ctrl_ovf_clr clears stat_ovf
//   stat_ovf              sticky per-channel overflow
module prach_tdm_mux #(
  parameter int NUM_CHN    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CHN*96-1:0]  din_dq,
  input  logic [NUM_CHN-1:0]     din_dv,
  input  logic                   sync_in,
  output logic [95:0]            dout_dq,
  output logic                   dout_dv,
  output logic [7:0]             dout_chn,
  output logic                   sync_out,
  input  logic [NUM_CHN-1:0]     ctrl_chn_en,
  input  logic                   ctrl_ovf_clr,
  output logic [NUM_CHN-1:0]     stat_ovf
);
  localparam int SW = $clog2(NUM_CHN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [SW-1:0]        s;
  logic                 sync_d;
  logic [95:0]          head [NUM_CHN];
  logic [NUM_CHN-1:0]   pop;
  logic [NUM_CHN-1:0]   ovf;
  for (genvar k = 0; k < NUM_CHN; k++) begin : g_chn
    logic [95:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          full;
    logic          wr_req;
    logic          wr;
    assign full   = cnt == CW'(FIFO_DEPTH);
    assign wr_req = din_dv[k] & ctrl_chn_en[k] & ~sync_in;
    // pop uses the registered occupancy, so a same-cycle write can never bypass
    assign pop[k] = (s == SW'(k)) & ctrl_chn_en[k] & (cnt != '0) & ~sync_in;
    // a full FIFO still accepts a write when its head leaves in the same cycle
    assign wr     = wr_req & (~full | pop[k]);
    assign ovf[k] = wr_req & full & ~pop[k];
    assign head[k] = mem[rp];
    always_ff @(posedge clk)
      if (wr) mem[wp] <= din_dq[k*96 +: 96];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else if (sync_in) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (wr) wp <= wp + AW'(1);
        if (pop[k]) rp <= rp + AW'(1);
        cnt <= cnt + CW'(wr) - CW'(pop[k]);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s        <= '0;
      sync_d   <= 1'b0;
      sync_out <= 1'b0;
      dout_dq  <= '0;
      dout_dv  <= 1'b0;
      dout_chn <= '0;
      stat_ovf <= '0;
    end else begin
      s        <= (sync_in || s == SW'(NUM_CHN-1)) ? '0 : s + SW'(1);
      sync_d   <= sync_in;
      // a repeated sync_in cancels the pending marker so only the last one fires
      sync_out <= sync_d & ~sync_in;
      dout_chn <= 8'(s);
      dout_dv  <= |pop;
      if (|pop) dout_dq <= head[s];
      // overflow set takes priority over the clear pulse
      stat_ovf <= (ctrl_ovf_clr ? '0 : stat_ovf) | ovf;
    end
endmodule
